video_timing_gen: RTL and testbench

Parametrised raster timing generator; the successor to the fixed CGA timing generator. Produces hs, vs, active_video, pixel coordinates and line/frame strobes for any progressive mode. Sync polarity is per-parameter, and a clock enable allows pixel-rate division. Sits between the pixel clock domain and the pixel source / video encoder (CGA replay, HDMI front end).

---
 rtl/video_timing_gen.sv | 100 ++++++++++
 tb/tb_video_timing_gen.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/video_timing_gen.sv
// Parametrised progressive raster timing generator: sync, blanking, pixel coordinates and strobes.
// Optional VTG_PREFETCH_EN adds a prefetch output one enabled cycle ahead of active_video.
module video_timing_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0,
    parameter int XW       = 11,
    parameter int YW       = 10
) (
    input  logic          pix_clk,
    input  logic          rst_n,
    input  logic          en,
    output logic          hs,
    output logic          vs,
    output logic          active_video,
    output logic [XW-1:0] x,
    output logic [YW-1:0] y,
    output logic          line_start,
`ifdef VTG_PREFETCH_EN
    output logic          prefetch,
`endif
    output logic          frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    if (H_ACTIVE < 1 || H_FP < 1 || H_SYNC < 1 || H_BP < 1 ||
        V_ACTIVE < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1) begin : g_bad_timing
        $error("video_timing_gen: every timing parameter must be >= 1");
    end
    if (H_TOTAL > (1 << XW)) begin : g_bad_xw
        $error("video_timing_gen: XW too small for H_TOTAL");
    end
    if (V_TOTAL > (1 << YW)) begin : g_bad_yw
        $error("video_timing_gen: YW too small for V_TOTAL");
    end

    localparam logic [XW-1:0] H_LAST   = XW'(H_TOTAL - 1);
    localparam logic [XW-1:0] H_ACT    = XW'(H_ACTIVE);
    localparam logic [XW-1:0] HS_START = XW'(H_ACTIVE + H_FP);
    localparam logic [XW-1:0] HS_END   = XW'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [YW-1:0] V_LAST   = YW'(V_TOTAL - 1);
    localparam logic [YW-1:0] V_ACT    = YW'(V_ACTIVE);
    localparam logic [YW-1:0] VS_START = YW'(V_ACTIVE + V_FP);
    localparam logic [YW-1:0] VS_END   = YW'(V_ACTIVE + V_FP + V_SYNC - 1);

    logic [XW-1:0] h_cnt, h_nxt;
    logic [YW-1:0] v_cnt, v_nxt;
    logic          h_wrap;

    always_comb begin
        h_wrap = (h_cnt == H_LAST);
        h_nxt  = h_wrap ? '0 : h_cnt + XW'(1);
        v_nxt  = v_cnt;
        if (h_wrap)
            v_nxt = (v_cnt == V_LAST) ? '0 : v_cnt + YW'(1);
    end

    // Outputs decode the position held before this cycle's increment, so
    // everything registered here lines up with x/y.
    always_ff @(posedge pix_clk) begin
        if (!rst_n) begin
            h_cnt        <= '0;
            v_cnt        <= '0;
            hs           <= ~HS_POL;
            vs           <= ~VS_POL;
            active_video <= 1'b0;
            x            <= '0;
            y            <= '0;
            line_start   <= 1'b0;
            frame_start  <= 1'b0;
`ifdef VTG_PREFETCH_EN
            prefetch     <= 1'b0;
`endif
        end else if (en) begin
            h_cnt        <= h_nxt;
            v_cnt        <= v_nxt;
            hs           <= (h_cnt >= HS_START && h_cnt <= HS_END) ? HS_POL : ~HS_POL;
            vs           <= (v_cnt >= VS_START && v_cnt <= VS_END) ? VS_POL : ~VS_POL;
            active_video <= (h_cnt < H_ACT) && (v_cnt < V_ACT);
            x            <= h_cnt;
            y            <= v_cnt;
            line_start   <= (h_cnt == '0);
            frame_start  <= (h_cnt == '0) && (v_cnt == '0);
`ifdef VTG_PREFETCH_EN
            // Announces that the next enabled output will be a visible pixel.
            prefetch     <= (h_nxt < H_ACT) && (v_nxt < V_ACT);
`endif
        end
    end

endmodule

// File: tb/tb_video_timing_gen.sv
// Randomised bench for video_timing_gen in an 8x6 mode; expected outputs come from a
// linear frame-position model, queued by the driver and popped by an independent monitor.
module tb_video_timing_gen;

    localparam int XW = 3;
    localparam int YW = 3;
    localparam int HT = 8;
    localparam int VT = 6;

    logic          pix_clk = 1'b0;
    logic          rst_n   = 1'b0;
    logic          en      = 1'b0;
    logic          hs, vs, active_video, line_start, frame_start;
    logic [XW-1:0] x;
    logic [YW-1:0] y;
`ifdef VTG_PREFETCH_EN
    logic          prefetch;
`endif

    video_timing_gen #(
        .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .HS_POL(1'b1), .VS_POL(1'b0), .XW(XW), .YW(YW)
    ) dut (
        .pix_clk(pix_clk), .rst_n(rst_n), .en(en),
        .hs(hs), .vs(vs), .active_video(active_video),
        .x(x), .y(y), .line_start(line_start),
`ifdef VTG_PREFETCH_EN
        .prefetch(prefetch),
`endif
        .frame_start(frame_start)
    );

    always #5 pix_clk = ~pix_clk;

    typedef struct {
        int x;
        int y;
        bit av, hs, vs, ls, fs, pf;
    } exp_t;

    exp_t q[$];
    int   pos = 0;
    int   n_chk = 0;
    int   n_pass = 0;

    // The frame is a flat sequence of HT*VT positions; each field follows from x/y directly.
    function automatic exp_t model(int p);
        exp_t r;
        int   nx;
        nx   = (p + 1) % (HT * VT);
        r.x  = p % HT;
        r.y  = p / HT;
        r.av = (r.x < 4) && (r.y < 3);
        r.hs = (r.x == 5) || (r.x == 6);
        r.vs = (r.y != 4);
        r.ls = (r.x == 0);
        r.fs = (p == 0);
        r.pf = ((nx % HT) < 4) && ((nx / HT) < 3);
        return r;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    task automatic cmp(input exp_t e, input string tag);
        chk({tag, ".x"}, int'(x), e.x);
        chk({tag, ".y"}, int'(y), e.y);
        chk({tag, ".active_video"}, int'(active_video), int'(e.av));
        chk({tag, ".hs"}, int'(hs), int'(e.hs));
        chk({tag, ".vs"}, int'(vs), int'(e.vs));
        chk({tag, ".line_start"}, int'(line_start), int'(e.ls));
        chk({tag, ".frame_start"}, int'(frame_start), int'(e.fs));
`ifdef VTG_PREFETCH_EN
        chk({tag, ".prefetch"}, int'(prefetch), int'(e.pf));
`endif
    endtask

    // Driver: inputs change on the falling edge; the model advances on every enabled, non-reset cycle.
    task automatic drive(input bit r, input bit e);
        @(negedge pix_clk);
        rst_n = r;
        en    = e;
        if (!r) pos = 0;
        else if (e) begin
            q.push_back(model(pos));
            pos = (pos + 1) % (HT * VT);
        end
    endtask

    // Monitor: enabled cycles pop an expectation, disabled cycles must hold, reset cycles show reset values.
    exp_t last;
    bit   fv = 1'b0;
    int   fc = 0;
    int   fa = 0;
    always begin
        bit   s_r, s_e;
        exp_t e;
        @(posedge pix_clk);
        s_r = rst_n;
        s_e = en;
        #2;
        if (!s_r) begin
            last = '{x: 0, y: 0, av: 1'b0, hs: 1'b0, vs: 1'b1, ls: 1'b0, fs: 1'b0, pf: 1'b0};
            cmp(last, "reset");
            fv = 1'b0;
        end else if (s_e) begin
            if (q.size() == 0) chk("queue_underflow", 1, 0);
            else begin
                e = q.pop_front();
                cmp(e, "run");
                last = e;
            end
            if (frame_start) begin
                if (fv) begin
                    chk("frame_period", fc, HT * VT);
                    chk("frame_active_count", fa, 12);
                end
                fv = 1'b1;
                fc = 0;
                fa = 0;
            end
            fc++;
            if (active_video) fa++;
        end else begin
            cmp(last, "hold");
        end
    end

    initial begin
        repeat (3) drive(1'b0, 1'b1);
        repeat (100) drive(1'b1, 1'b1);
        for (int i = 0; i < 200; i++) drive(1'b1, (i % 2) == 0);
        repeat (200) drive(1'b1, $urandom_range(0, 3) != 0);
        // Walk to (x=2, y=1) and reset mid-frame.
        for (int i = 0; i < 2 * HT * VT && pos != 10; i++) drive(1'b1, 1'b1);
        repeat (3) drive(1'b0, 1'($urandom_range(0, 1)));
        repeat (60) drive(1'b1, 1'b1);
        repeat (400) drive($urandom_range(0, 49) != 0, $urandom_range(0, 2) != 0);
        repeat (60) drive(1'b1, 1'b1);
        repeat (3) drive(1'b1, 1'b0);
        chk("queue_drained", q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
